// File: rtl/alu_wide_seq_if.sv
// Bundle of the request, response and ALU-facing signals of alu_wide_seq.
// The slave modport is the sequencer; the master modport is everything around it.
interface alu_wide_seq_if;
    // Both ports use valid/ready handshakes. A transfer happens on a rising edge
    // where valid and ready are both high. Valid and its payload hold until then.
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [7:0]  alu_input_a;
    logic [7:0]  alu_input_b;
    logic [2:0]  alu_opcode;
    logic [7:0]  alu_out;
    logic        zero;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_result;
    logic        rsp_zero;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready, alu_out, zero,
        input  req_ready, alu_input_a, alu_input_b, alu_opcode,
               rsp_valid, rsp_result, rsp_zero
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready, alu_out, zero,
        output req_ready, alu_input_a, alu_input_b, alu_opcode,
               rsp_valid, rsp_result, rsp_zero
    );
endinterface

// File: rtl/alu_wide_seq.sv
// Sequences 16-bit AND/ADD/XOR/NE commands as byte-wide passes through a shared
// combinational 8-bit ALU, one pass per cycle.
module alu_wide_seq (
    input  logic           clk,
    input  logic           reset_n,
    alu_wide_seq_if.slave  bus,
    output logic [2:0]     o_dbg_state
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_P0   = 3'd1;
    localparam logic [2:0] S_P1   = 3'd2;
    localparam logic [2:0] S_P2   = 3'd3;
    localparam logic [2:0] S_P3   = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    localparam logic [1:0] OP_AND = 2'd0;
    localparam logic [1:0] OP_ADD = 2'd1;
    localparam logic [1:0] OP_XOR = 2'd2;
    localparam logic [1:0] OP_NE  = 2'd3;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_XOR = 3'b010;
    localparam logic [2:0] ALU_LTU = 3'b011;
    localparam logic [2:0] ALU_NE  = 3'b110;

    logic [2:0]  r_state;
    logic [1:0]  r_op;
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic [15:0] r_result;
    logic        r_carry;
    logic        r_zero_lo;
    logic        r_zero;

    logic [2:0]  w_next_state;
    logic [2:0]  w_pass_opc;
    logic [7:0]  w_alu_a;
    logic [7:0]  w_alu_b;
    logic [2:0]  w_alu_opc;
    logic        w_is_add;
    logic        w_accept;

    assign w_is_add = (r_op == OP_ADD);
    assign w_accept = (r_state == S_IDLE) && bus.req_valid;

    always_comb begin
        w_pass_opc = ALU_AND;
        case (r_op)
            OP_AND:  w_pass_opc = ALU_AND;
            OP_ADD:  w_pass_opc = ALU_ADD;
            OP_XOR:  w_pass_opc = ALU_XOR;
            OP_NE:   w_pass_opc = ALU_NE;
            default: w_pass_opc = ALU_AND;
        endcase
    end

    // ADD detects the low-byte carry as (low sum < low addend) in P1.
    always_comb begin
        w_alu_a   = 8'h00;
        w_alu_b   = 8'h00;
        w_alu_opc = ALU_AND;
        case (r_state)
            S_P0: begin
                w_alu_a   = r_a[7:0];
                w_alu_b   = r_b[7:0];
                w_alu_opc = w_pass_opc;
            end
            S_P1: begin
                if (w_is_add) begin
                    w_alu_a   = r_result[7:0];
                    w_alu_b   = r_a[7:0];
                    w_alu_opc = ALU_LTU;
                end else begin
                    w_alu_a   = r_a[15:8];
                    w_alu_b   = r_b[15:8];
                    w_alu_opc = w_pass_opc;
                end
            end
            S_P2: begin
                w_alu_a   = r_a[15:8];
                w_alu_b   = r_b[15:8];
                w_alu_opc = ALU_ADD;
            end
            S_P3: begin
                w_alu_a   = r_result[15:8];
                w_alu_b   = {7'b0, r_carry};
                w_alu_opc = ALU_ADD;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (bus.req_valid) w_next_state = S_P0;
            S_P0:    w_next_state = S_P1;
            S_P1:    w_next_state = w_is_add ? S_P2 : S_DONE;
            S_P2:    w_next_state = S_P3;
            S_P3:    w_next_state = S_DONE;
            S_DONE:  if (bus.rsp_ready) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_op      <= OP_AND;
            r_a       <= 16'h0000;
            r_b       <= 16'h0000;
            r_result  <= 16'h0000;
            r_carry   <= 1'b0;
            r_zero_lo <= 1'b0;
            r_zero    <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_op   <= bus.req_op;
                r_a    <= bus.req_a;
                r_b    <= bus.req_b;
                r_zero <= 1'b0;
            end
            case (r_state)
                S_P0: begin
                    r_zero_lo <= bus.zero;
                    if (r_op == OP_NE) r_result <= {15'b0, bus.alu_out[0]};
                    else               r_result <= {8'h00, bus.alu_out};
                end
                S_P1: begin
                    if (w_is_add) begin
                        r_carry <= bus.alu_out[0];
                    end else begin
                        r_zero <= r_zero_lo & bus.zero;
                        if (r_op == OP_NE) r_result[0]    <= r_result[0] | bus.alu_out[0];
                        else               r_result[15:8] <= bus.alu_out;
                    end
                end
                S_P2: r_result[15:8] <= bus.alu_out;
                S_P3: begin
                    r_result[15:8] <= bus.alu_out;
                    r_zero         <= r_zero_lo & bus.zero;
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready   = (r_state == S_IDLE);
    assign bus.rsp_valid   = (r_state == S_DONE);
    assign bus.rsp_result  = r_result;
    assign bus.rsp_zero    = r_zero;
    assign bus.alu_input_a = w_alu_a;
    assign bus.alu_input_b = w_alu_b;
    assign bus.alu_opcode  = w_alu_opc;
    assign o_dbg_state     = r_state;
endmodule
